hook_ctrl: RTL
==============

# hook_ctrl

Frame-rate hook and fishing-line controller. It produces the hook position in tenths of a pixel (`h_position`, `v_position`), the line-cut status (`cut`, `cut_v`) and the game phase (`state`) consumed by the per-pixel colour generator. It sits between the debounced player and game-event inputs and the VGA pixel path, and advances once per `frame_tick` from the VGA timing generator.

## Interface
- `H_HOOK`, 2790: fixed hook x position in tenths of a pixel (column 279).
- `V_TOP`, 620: rest/top hook y in tenths of a pixel (row 62).
- `V_BOTTOM`, 4500: deepest reachable y while the line is intact.
- `V_FLOOR`, 4790: y at which a cut hook is lost (row 479).
- `DROP_SPEED`, 25: descent per frame, intact line, `reel` low.
- `REEL_SPEED`, 40: ascent per frame while `reel` is high.
- `FALL_SPEED`, 30: descent per frame after a cut.
- `RESULT_FRAMES`, 120: frames spent in LOST/LANDED before READY.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `start`, in, 1: one-cycle pulse that casts the hook.
- `reel`, in, 1: level signal; reel in while high.
- `cut_in`, in, 1: one-cycle pulse; the line snaps.
- `h_position`, out, 14: hook x in tenths of a pixel, registered.
- `v_position`, out, 14: hook y in tenths of a pixel, registered.
- `cut`, out, 1: line has been cut this cast.
- `cut_v`, out, 10: pixel row where the line ends after a cut.
- `state`, out, 2: 0 READY, 1 FISHING, 2 LOST, 3 LANDED.

## Operation
- READY (0): `v_position`=V_TOP, `cut`=0, `cut_v`=V_TOP/10. A `start` pulse moves to FISHING. `start` is ignored in all other states.
- FISHING (1) with `cut`=0, evaluated on each `frame_tick`:
  - If `reel`=1 and v>V_TOP: v -= REEL_SPEED, saturating at V_TOP. Reaching V_TOP on this tick moves to LANDED on the same edge.
  - If `reel`=1 and v==V_TOP: no motion and no transition. Landing requires the hook to have descended first.
  - If `reel`=0: v += DROP_SPEED, saturating at V_BOTTOM. The hook holds at V_BOTTOM.
- `cut_in` in FISHING with `cut`=0:
  - Set `cut`=1 and latch `cut_v` = v_position/10, using the current registered value (truncating divide, result ≤ 479).
  - `state` stays 1, so the line is drawn only down to `cut_v`.
- FISHING with `cut`=1:
  - `reel` is ignored. Each tick, v += FALL_SPEED, saturating at V_FLOOR.
  - Reaching V_FLOOR moves to LOST.
- LOST (2) / LANDED (3):
  - v, `cut` and `cut_v` hold. Each tick increments a result counter.
  - When the count reaches RESULT_FRAMES, return to READY: clear the counter, set v=V_TOP, `cut`=0, `cut_v`=V_TOP/10.
- `cut_in` is ignored outside FISHING and when `cut` is already 1.
- `h_position` is constantly H_HOOK.
- Arithmetic is done at 15 bits before saturation, so there is no wrap-around at the 14-bit limit.

## Timing
- All outputs are registered. A change caused by a tick or pulse in cycle N is visible in cycle N+1.
- Position updates occur only on `frame_tick` cycles.
- `cut_in` together with `frame_tick` in the same cycle: the cut wins. `cut_v` uses the pre-tick v, and v does not move that cycle.
- `cut_in` in the same cycle a reel tick would land the hook: the cut wins and there is no LANDED.
- `start` together with `frame_tick` in READY: enter FISHING only; the first motion happens on the next tick.
- `rst` overrides everything, including mid-cast. Reset values: `state`=0, `h_position`=H_HOOK, `v_position`=V_TOP, `cut`=0, `cut_v`=62, result counter=0.

## Test plan
- Reset, then `start`, then 4 ticks with `reel`=0 -> `state`=1 and `v_position` goes 645, 670, 695, 720.
- From v=720, hold `reel`=1 for 3 ticks -> v goes 680, 640, then 620 with `state`=3. After 120 more ticks -> `state`=0 and v=620.
- Drop for 160 ticks with `reel`=0 -> v saturates at 4500 from tick 156 and `state` stays 1.
- At v=720, pulse `cut_in` in the same cycle as `frame_tick` -> `cut`=1, `cut_v`=72, v stays 720.
  - Next, 136 ticks with `reel`=1 -> v=4790 and `state`=2.
  - Next, 120 ticks -> `state`=0, `cut`=0, `cut_v`=62.
- In READY with `reel`=1, `start`, then 5 ticks -> v stays 620 and `state` stays 1.
- Assert `rst` mid-fall at v=2000 with `cut`=1 -> next cycle all outputs equal their reset values.

Source files
------------

// File: rtl/hook_ctrl.sv
// hook_ctrl: per-frame hook/line controller; in clk rst frame_tick start reel cut_in, out h_position v_position cut cut_v state
module hook_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        reel,
  input  logic        cut_in,
  output logic [13:0] h_position,
  output logic [13:0] v_position,
  output logic        cut,
  output logic [9:0]  cut_v,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {READY, FISHING, LOST, LANDED} state_t;
  localparam logic [13:0] H_HOOK = 14'd2790;
  localparam logic [14:0] V_TOP = 15'd620;
  localparam logic [14:0] V_BOTTOM = 15'd4500;
  localparam logic [14:0] V_FLOOR = 15'd4790;
  localparam logic [14:0] DROP_SPEED = 15'd25;
  localparam logic [14:0] REEL_SPEED = 15'd40;
  localparam logic [14:0] FALL_SPEED = 15'd30;
  localparam logic [6:0] RESULT_FRAMES = 7'd120;
  localparam logic [9:0] CUT_V_TOP = 10'd62;
  state_t state_q, state_d;
  logic [13:0] v_q, v_d;
  logic cut_q, cut_d;
  logic [9:0] cut_v_q, cut_v_d;
  logic [6:0] cnt_q, cnt_d;
  logic [14:0] v_ext, drop_sum, fall_sum, reel_diff;
  logic [13:0] v_quot;
  logic reel_landing;
  assign v_ext = {1'b0, v_q};
  assign drop_sum = v_ext + DROP_SPEED;
  assign fall_sum = v_ext + FALL_SPEED;
  assign reel_diff = v_ext - REEL_SPEED;
  assign reel_landing = v_ext <= V_TOP + REEL_SPEED;
  assign v_quot = v_q / 14'd10;
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    cut_d = cut_q;
    cut_v_d = cut_v_q;
    cnt_d = cnt_q;
    unique case (state_q)
      READY: state_d = start ? FISHING : READY;
      FISHING: begin
        // a cut takes priority over any motion or landing in the same cycle
        if (!cut_q && cut_in) begin
          cut_d = 1'b1;
          cut_v_d = v_quot[9:0];
        end else if (frame_tick && cut_q) begin
          v_d = fall_sum >= V_FLOOR ? V_FLOOR[13:0] : fall_sum[13:0];
          state_d = fall_sum >= V_FLOOR ? LOST : FISHING;
        end else if (frame_tick && reel && v_ext > V_TOP) begin
          v_d = reel_landing ? V_TOP[13:0] : reel_diff[13:0];
          state_d = reel_landing ? LANDED : FISHING;
        end else if (frame_tick && !reel) begin
          v_d = drop_sum >= V_BOTTOM ? V_BOTTOM[13:0] : drop_sum[13:0];
        end
      end
      default: begin
        if (frame_tick && cnt_q == RESULT_FRAMES - 7'd1) begin
          state_d = READY;
          cnt_d = '0;
          v_d = V_TOP[13:0];
          cut_d = 1'b0;
          cut_v_d = CUT_V_TOP;
        end else if (frame_tick) begin
          cnt_d = cnt_q + 7'd1;
        end
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= READY;
      v_q <= V_TOP[13:0];
      cut_q <= 1'b0;
      cut_v_q <= CUT_V_TOP;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      cut_q <= cut_d;
      cut_v_q <= cut_v_d;
      cnt_q <= cnt_d;
    end
  end
  assign h_position = H_HOOK;
  assign v_position = v_q;
  assign cut = cut_q;
  assign cut_v = cut_v_q;
  assign state = state_q;
endmodule
